// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : timer_pkg
// Description : Shared types and control-byte field positions for the
//               programmable down-counting timer.
// Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Default counter / reload width (must match the timer_in register width)
  localparam int CNT_W_DEFAULT = 8;

  // Width of the prescale exponent field inside the control byte
  localparam int PS_W = 3;

  // Bit positions inside the c_enable control byte
  localparam int EN_B   = 0;
  localparam int AR_B   = 1;
  localparam int IE_B   = 2;
  localparam int PS_LSB = 3;
  localparam int PS_MSB = 5;
  localparam int SCLR_B = 7;

  // Timer FSM states; 2'b11 is illegal and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_EXPIRED = 2'b10
  } state_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : timer_prescaler
// Description : Free-running divide-by-2^ps counter that produces the only
//               decrement ticks for the timer. If ps shrinks below the current
//               count, the counter runs on and wraps at 2^PS_MAX.
//               PS_MAX must be at least 2^PS_W - 1 so every ps value fits.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_prescaler
  import timer_pkg::*;
#(
  parameter int PS_MAX = 7
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            run,
  input  logic            clr,
  input  logic [PS_W-1:0] ps,
  output logic            tick
);

  localparam int             C_PW   = PS_MAX + 1;
  localparam logic [PS_MAX:0] c_ONE  = C_PW'(1);
  localparam logic [PS_MAX:0] c_WRAP = C_PW'((1 << PS_MAX) - 1);

  logic [PS_MAX:0] r_cnt;
  logic [PS_MAX:0] w_term;

  // Terminal value for the currently selected exponent, re-evaluated every cycle
  always_comb begin
    w_term = (c_ONE << ps) - c_ONE;
    tick   = run && (r_cnt == w_term);
  end

  // Prescale counter: cleared on request, wraps on tick or at the 2^PS_MAX limit
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= (tick || (r_cnt >= c_WRAP)) ? '0 : (r_cnt + c_ONE);
    end
  end

endmodule : timer_prescaler
`default_nettype wire

// File: rtl/timer_core.sv
`default_nettype none
// ============================================================================
// Module      : timer_core
// Description : Programmable down-counting timer fed by the APB register
//               slave. Holds the run FSM, count, reload value and sticky irq.
// Revision    : 1.0 - initial release
// ============================================================================
module timer_core
  import timer_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEFAULT,
  parameter int PS_MAX = 7
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic [CNT_W-1:0] timer_in,
  input  logic [7:0]       c_enable,
  input  logic             load_strobe,
  input  logic             irq_clr,
  output logic [CNT_W-1:0] count,
  output logic             expired,
  output logic             irq,
  output logic             busy
);

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_reload_q;

  logic            w_en, w_ar, w_ie, w_sclr;
  logic [PS_W-1:0] w_ps;
  logic            w_pre_run;
  logic            w_tick;
  logic            w_fire;
  logic            w_unused_rsvd;

  // Control-byte decode; the reserved bit is deliberately ignored
  always_comb begin
    w_en          = c_enable[EN_B];
    w_ar          = c_enable[AR_B];
    w_ie          = c_enable[IE_B];
    w_sclr        = c_enable[SCLR_B];
    w_ps          = c_enable[PS_MSB:PS_LSB];
    w_unused_rsvd = c_enable[6];
    // Prescaler advances only while genuinely counting; everything else clears it
    w_pre_run     = (r_state == ST_RUN) && w_en && !w_sclr && !load_strobe;
    // Terminal-count event: a tick that takes the counter off 1
    w_fire        = w_tick && (count == c_CNT_ONE);
  end

  timer_prescaler #(
    .PS_MAX (PS_MAX)
  ) u_prescaler (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .run     (w_pre_run),
    .clr     (!w_pre_run),
    .ps      (w_ps),
    .tick    (w_tick)
  );

  // Main FSM with count/reload registers and registered expired/busy outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= ST_IDLE;
      count      <= '0;
      r_reload_q <= '0;
      expired    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (w_sclr) begin
        count   <= '0;
        r_state <= ST_IDLE;
        busy    <= 1'b0;
      end else if (load_strobe) begin
        r_reload_q <= timer_in;
        count      <= timer_in;
        if (w_en && (timer_in != '0)) begin
          r_state <= ST_RUN;
          busy    <= 1'b1;
        end else begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_en && (count != '0)) begin
              r_state <= ST_RUN;
              busy    <= 1'b1;
            end
          end
          ST_RUN: begin
            if (!w_en) begin
              r_state <= ST_IDLE;
              busy    <= 1'b0;
            end else if (w_tick) begin
              if (w_fire) begin
                expired <= 1'b1;
                if (w_ar && (r_reload_q != '0)) begin
                  count <= r_reload_q;
                end else begin
                  count   <= '0;
                  r_state <= ST_EXPIRED;
                  busy    <= 1'b0;
                end
              end else begin
                count <= count - c_CNT_ONE;
              end
            end
          end
          ST_EXPIRED: begin
            if (!w_en) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Sticky interrupt: a new terminal count wins over a same-cycle clear
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      irq <= 1'b0;
    end else if (w_fire && w_ie) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end

endmodule : timer_core
`default_nettype wire
